id_queue: RTL and testbench

Decode stage with a parametrised instruction queue and a registered, valid/ready output toward EX. It accepts (pc, inst) pairs from IF through a handshake, buffers up to DEPTH of them, and decodes the queue head against the regfile. One decoded instruction per cycle is presented in an output register. It replaces the purely combinational decoder and adds back-pressure, flush, illegal-instruction flagging, x0-write suppression and optional write-back forwarding.

---
 rtl/id_queue.sv | 227 ++++++++++++++++++++++
 tb/tb_id_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_queue.sv
// Decode stage: DEPTH-entry (pc, inst) queue from IF, RV32I head decode, registered valid/ready output to EX.
// Define ID_FWD_EN to add the write-back forwarding ports (fwd_we_i, fwd_waddr_i, fwd_wdata_i).
package id_queue_pkg;
   localparam logic [6:0] OpcodeNOP    = 7'h00;
   localparam logic [6:0] OpcodeLUI    = 7'h37;
   localparam logic [6:0] OpcodeAUIPC  = 7'h17;
   localparam logic [6:0] OpcodeJAL    = 7'h6f;
   localparam logic [6:0] OpcodeJALR   = 7'h67;
   localparam logic [6:0] OpcodeBRANCH = 7'h63;
   localparam logic [6:0] OpcodeLOAD   = 7'h03;
   localparam logic [6:0] OpcodeSTORE  = 7'h23;
   localparam logic [6:0] OpcodeOPIMM  = 7'h13;
   localparam logic [6:0] OpcodeOP     = 7'h33;

   localparam logic [5:0] OptNOP   = 6'd0,  OptLUI  = 6'd1,  OptAUIPC = 6'd2,  OptJAL  = 6'd3;
   localparam logic [5:0] OptJALR  = 6'd4,  OptBEQ  = 6'd5,  OptBNE   = 6'd6,  OptBLT  = 6'd7;
   localparam logic [5:0] OptBGE   = 6'd8,  OptBLTU = 6'd9,  OptBGEU  = 6'd10, OptLB   = 6'd11;
   localparam logic [5:0] OptLH    = 6'd12, OptLW   = 6'd13, OptLBU   = 6'd14, OptLHU  = 6'd15;
   localparam logic [5:0] OptSB    = 6'd16, OptSH   = 6'd17, OptSW    = 6'd18, OptADDI = 6'd19;
   localparam logic [5:0] OptSLTI  = 6'd20, OptSLTIU= 6'd21, OptXORI  = 6'd22, OptORI  = 6'd23;
   localparam logic [5:0] OptANDI  = 6'd24, OptSLLI = 6'd25, OptSRLI  = 6'd26, OptSRAI = 6'd27;
   localparam logic [5:0] OptADD   = 6'd28, OptSUB  = 6'd29, OptSLL   = 6'd30, OptSLT  = 6'd31;
   localparam logic [5:0] OptSLTU  = 6'd32, OptXOR  = 6'd33, OptSRL   = 6'd34, OptSRA  = 6'd35;
   localparam logic [5:0] OptOR    = 6'd36, OptAND  = 6'd37;
endpackage

module id_queue
   import id_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int OPT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             inst_valid_i,
   output logic             inst_ready_o,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [31:0]      inst_i,
   output logic             re1_o,
   output logic             re2_o,
   output logic [4:0]       raddr1_o,
   output logic [4:0]       raddr2_o,
   input  logic [XLEN-1:0]  rdata1_i,
   input  logic [XLEN-1:0]  rdata2_i,
`ifdef ID_FWD_EN
   input  logic             fwd_we_i,
   input  logic [4:0]       fwd_waddr_i,
   input  logic [XLEN-1:0]  fwd_wdata_i,
`endif
   output logic             valid_o,
   input  logic             ready_i,
   output logic [XLEN-1:0]  pc_o,
   output logic [XLEN-1:0]  rdata1_o,
   output logic [XLEN-1:0]  rdata2_o,
   output logic [XLEN-1:0]  imm_o,
   output logic [6:0]       opcode_o,
   output logic [OPT_W-1:0] opt_o,
   output logic [4:0]       waddr_o,
   output logic [4:0]       shamt_o,
   output logic             we_o,
   output logic             illegal_o
);
   localparam int PW = $clog2(DEPTH);

   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [31:0]     inst_mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW:0]     count;
   logic            enq, load, empty;
   logic [XLEN-1:0] head_pc, src1, src2;
   logic [31:0]     hi;

   // Full queue refuses input even when the head leaves this cycle (no pass-through).
   assign inst_ready_o = !rst && (count != (PW+1)'(DEPTH));
   assign enq          = inst_valid_i && inst_ready_o;
   assign empty        = (count == '0);
   assign load         = !empty && (!valid_o || ready_i);
   assign head_pc      = pc_mem[rd_ptr];
   // An empty queue decodes as all-zero, which is illegal and so drops both read enables.
   assign hi           = empty ? 32'h0 : inst_mem[rd_ptr];
   assign raddr1_o     = hi[19:15];
   assign raddr2_o     = hi[24:20];

   // NOTE: storage has no reset; count and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem[wr_ptr]   <= pc_i;
         inst_mem[wr_ptr] <= inst_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (enq)  wr_ptr <= wr_ptr + PW'(1);
         if (load) rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(enq) - (PW+1)'(load);
      end
   end

   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, dec_imm;
   logic [5:0]      dec_opt;
   logic [4:0]      dec_shamt;
   logic            dec_re1, dec_re2, dec_rd_en, dec_ill, dec_we;
   logic [2:0]      f3;
   logic [6:0]      f7;

   assign f3    = hi[14:12];
   assign f7    = hi[31:25];
   assign imm_i = {{(XLEN-11){hi[31]}}, hi[30:20]};
   assign imm_s = {{(XLEN-11){hi[31]}}, hi[30:25], hi[11:7]};
   assign imm_b = {{(XLEN-12){hi[31]}}, hi[7], hi[30:25], hi[11:8], 1'b0};
   assign imm_u = {{(XLEN-31){hi[31]}}, hi[30:12], 12'h0};
   assign imm_j = {{(XLEN-20){hi[31]}}, hi[19:12], hi[20], hi[30:21], 1'b0};

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      dec_opt = OptNOP; dec_imm = '0; dec_shamt = '0;
      dec_re1 = 1'b0; dec_re2 = 1'b0; dec_rd_en = 1'b0; dec_ill = 1'b0;
      case (hi[6:0])
         OpcodeLUI:   begin dec_opt = OptLUI;   dec_imm = imm_u; dec_rd_en = 1'b1; end
         OpcodeAUIPC: begin dec_opt = OptAUIPC; dec_imm = imm_u; dec_rd_en = 1'b1; end
         OpcodeJAL:   begin dec_opt = OptJAL;   dec_imm = imm_j; dec_rd_en = 1'b1; end
         OpcodeJALR: begin
            dec_opt = OptJALR; dec_imm = imm_i; dec_re1 = 1'b1; dec_rd_en = 1'b1;
            dec_ill = (f3 != 3'd0);
         end
         OpcodeBRANCH: begin
            dec_imm = imm_b; dec_re1 = 1'b1; dec_re2 = 1'b1;
            case (f3)
               3'd0: dec_opt = OptBEQ;  3'd1: dec_opt = OptBNE;
               3'd4: dec_opt = OptBLT;  3'd5: dec_opt = OptBGE;
               3'd6: dec_opt = OptBLTU; 3'd7: dec_opt = OptBGEU;
               default: dec_ill = 1'b1;
            endcase
         end
         OpcodeLOAD: begin
            dec_imm = imm_i; dec_re1 = 1'b1; dec_rd_en = 1'b1;
            case (f3)
               3'd0: dec_opt = OptLB;  3'd1: dec_opt = OptLH; 3'd2: dec_opt = OptLW;
               3'd4: dec_opt = OptLBU; 3'd5: dec_opt = OptLHU;
               default: dec_ill = 1'b1;
            endcase
         end
         OpcodeSTORE: begin
            dec_imm = imm_s; dec_re1 = 1'b1; dec_re2 = 1'b1;
            case (f3)
               3'd0: dec_opt = OptSB; 3'd1: dec_opt = OptSH; 3'd2: dec_opt = OptSW;
               default: dec_ill = 1'b1;
            endcase
         end
         OpcodeOPIMM: begin
            dec_imm = imm_i; dec_re1 = 1'b1; dec_rd_en = 1'b1;
            case (f3)
               3'd0: dec_opt = OptADDI; 3'd2: dec_opt = OptSLTI; 3'd3: dec_opt = OptSLTIU;
               3'd4: dec_opt = OptXORI; 3'd6: dec_opt = OptORI;  3'd7: dec_opt = OptANDI;
               3'd1: begin dec_opt = OptSLLI; dec_shamt = hi[24:20]; dec_ill = (f7 != 7'h00); end
               default: begin
                  dec_shamt = hi[24:20];
                  if (f7 == 7'h00)      dec_opt = OptSRLI;
                  else if (f7 == 7'h20) dec_opt = OptSRAI;
                  else                  dec_ill = 1'b1;
               end
            endcase
         end
         OpcodeOP: begin
            dec_re1 = 1'b1; dec_re2 = 1'b1; dec_rd_en = 1'b1;
            case ({f7, f3})
               {7'h00, 3'd0}: dec_opt = OptADD;  {7'h20, 3'd0}: dec_opt = OptSUB;
               {7'h00, 3'd1}: dec_opt = OptSLL;  {7'h00, 3'd2}: dec_opt = OptSLT;
               {7'h00, 3'd3}: dec_opt = OptSLTU; {7'h00, 3'd4}: dec_opt = OptXOR;
               {7'h00, 3'd5}: dec_opt = OptSRL;  {7'h20, 3'd5}: dec_opt = OptSRA;
               {7'h00, 3'd6}: dec_opt = OptOR;   {7'h00, 3'd7}: dec_opt = OptAND;
               default: dec_ill = 1'b1;
            endcase
         end
         default: dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec_opt = OptNOP; dec_imm = '0; dec_shamt = '0;
         dec_re1 = 1'b0; dec_re2 = 1'b0; dec_rd_en = 1'b0;
      end
   end

   assign re1_o  = dec_re1;
   assign re2_o  = dec_re2;
   assign dec_we = dec_rd_en && (hi[11:7] != 5'd0);

`ifdef ID_FWD_EN
   assign src1 = (fwd_we_i && fwd_waddr_i != 5'd0 && fwd_waddr_i == raddr1_o) ? fwd_wdata_i : rdata1_i;
   assign src2 = (fwd_we_i && fwd_waddr_i != 5'd0 && fwd_waddr_i == raddr2_o) ? fwd_wdata_i : rdata2_i;
`else
   assign src1 = rdata1_i;
   assign src2 = rdata2_i;
`endif

   // Flush only drops valid_o; the remaining fields keep their last values.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_o  <= 1'b0;  pc_o     <= '0;  rdata1_o <= '0;  rdata2_o  <= '0;
         imm_o    <= '0;    opcode_o <= OpcodeNOP;            opt_o     <= OPT_W'(OptNOP);
         waddr_o  <= '0;    shamt_o  <= '0;  we_o     <= 1'b0; illegal_o <= 1'b0;
      end else if (flush) begin
         valid_o <= 1'b0;
      end else if (load) begin
         valid_o   <= 1'b1;
         pc_o      <= head_pc;
         rdata1_o  <= src1;
         rdata2_o  <= src2;
         imm_o     <= dec_imm;
         opcode_o  <= hi[6:0];
         opt_o     <= OPT_W'(dec_opt);
         waddr_o   <= dec_rd_en ? hi[11:7] : 5'd0;
         shamt_o   <= dec_shamt;
         we_o      <= dec_we;
         illegal_o <= dec_ill;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_id_queue.sv
// Self-checking bench for id_queue: decode vector table plus backpressure, flush, wrap, reset
// and (with ID_FWD_EN) forwarding sequences; outputs are checked by a scoreboard of expected records.
module tb_id_queue;
   import id_queue_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, inst_valid_i, ready_i;
   logic [31:0] pc_i, inst_i, rdata1_i, rdata2_i;
   logic        inst_ready_o, re1_o, re2_o, valid_o, we_o, illegal_o;
   logic [4:0]  raddr1_o, raddr2_o, waddr_o, shamt_o;
   logic [31:0] pc_o, rdata1_o, rdata2_o, imm_o;
   logic [6:0]  opcode_o;
   logic [5:0]  opt_o;
   logic        fwd_we_i;
   logic [4:0]  fwd_waddr_i;
   logic [31:0] fwd_wdata_i;

   always #5 clk = ~clk;

   id_queue #(.DEPTH(4), .XLEN(32), .OPT_W(6)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
      .pc_i(pc_i), .inst_i(inst_i),
      .re1_o(re1_o), .re2_o(re2_o), .raddr1_o(raddr1_o), .raddr2_o(raddr2_o),
      .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
`ifdef ID_FWD_EN
      .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
`endif
      .valid_o(valid_o), .ready_i(ready_i),
      .pc_o(pc_o), .rdata1_o(rdata1_o), .rdata2_o(rdata2_o), .imm_o(imm_o),
      .opcode_o(opcode_o), .opt_o(opt_o), .waddr_o(waddr_o), .shamt_o(shamt_o),
      .we_o(we_o), .illegal_o(illegal_o)
   );

   // Regfile model: combinational read of a fixed image.
   logic [31:0] regs [32];
   assign rdata1_i = regs[raddr1_o];
   assign rdata2_i = regs[raddr2_o];

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [5:0]  opt;
      logic [31:0] imm;
      logic [4:0]  waddr;
      logic [4:0]  shamt;
      logic        we, re1, re2, ill;
      logic [31:0] rd1, rd2;
   } vec_t;

   vec_t tbl [14];
   vec_t sb [$];
   vec_t cur;
   int   n_cmp = 0, n_fail = 0, n_out = 0;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic [5:0] opt,
                               input logic [31:0] imm, input logic [4:0] waddr, input logic [4:0] shamt,
                               input logic we, input logic re1, input logic re2, input logic ill);
      vec_t v;
      v.pc = pc; v.inst = inst; v.opt = opt; v.imm = imm; v.waddr = waddr; v.shamt = shamt;
      v.we = we; v.re1 = re1; v.re2 = re2; v.ill = ill; v.rd1 = '0; v.rd2 = '0;
      return v;
   endfunction

   task automatic offer(input vec_t v);
      vec_t t;
      t = v;
      t.rd1 = v.re1 ? regs[v.inst[19:15]] : 32'h0;
      t.rd2 = v.re2 ? regs[v.inst[24:20]] : 32'h0;
      cur = t;
      pc_i = v.pc;
      inst_i = v.inst;
      inst_valid_i = 1'b1;
   endtask

   // Scoreboard: push on an accepted offer, pop and compare on each EX transfer.
   always @(negedge clk) begin
      if (rst || flush) begin
         sb.delete();
      end else begin
         if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
               check("unexpected_out", {pc_o, opt_o}, 192'h0);
            end else begin
               vec_t e;
               e = sb.pop_front();
               n_out++;
               check($sformatf("out_pc_%0h", e.pc),
                     {pc_o, opcode_o, opt_o, imm_o, waddr_o, shamt_o, we_o, illegal_o,
                      e.re1 ? rdata1_o : 32'h0, e.re2 ? rdata2_o : 32'h0},
                     {e.pc, e.inst[6:0], e.opt, e.imm, e.waddr, e.shamt, e.we, e.ill, e.rd1, e.rd2});
            end
         end
         if (inst_valid_i && inst_ready_o) sb.push_back(cur);
      end
   end

   initial begin
      int acc, k, base, vcnt;
      logic ok, a;
      for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i) * 32'h11;
      regs[0] = 32'h0;
      regs[1] = 32'h7;

      tbl[0]  = mk(32'h100, 32'h00500093, OptADDI,  32'h5,        5'd1, 5'd0, 1, 1, 0, 0);
      tbl[1]  = mk(32'h104, 32'hFFFFFFFF, OptNOP,   32'h0,        5'd0, 5'd0, 0, 0, 0, 1);
      tbl[2]  = mk(32'h108, 32'h00000013, OptADDI,  32'h0,        5'd0, 5'd0, 0, 1, 0, 0);
      tbl[3]  = mk(32'h10C, 32'h00108133, OptADD,   32'h0,        5'd2, 5'd0, 1, 1, 1, 0);
      tbl[4]  = mk(32'h110, 32'h401101B3, OptSUB,   32'h0,        5'd3, 5'd0, 1, 1, 1, 0);
      tbl[5]  = mk(32'h114, 32'h123452B7, OptLUI,   32'h12345000, 5'd5, 5'd0, 1, 0, 0, 0);
      tbl[6]  = mk(32'h118, 32'h0020A423, OptSW,    32'h8,        5'd0, 5'd0, 0, 1, 1, 0);
      tbl[7]  = mk(32'h11C, 32'hFE208EE3, OptBEQ,   32'hFFFFFFFC, 5'd0, 5'd0, 0, 1, 1, 0);
      tbl[8]  = mk(32'h120, 32'h008000EF, OptJAL,   32'h8,        5'd1, 5'd0, 1, 0, 0, 0);
      tbl[9]  = mk(32'h124, 32'h4071D213, OptSRAI,  32'h407,      5'd4, 5'd7, 1, 1, 0, 0);
      tbl[10] = mk(32'h128, 32'hFFF12303, OptLW,    32'hFFFFFFFF, 5'd6, 5'd0, 1, 1, 0, 0);
      tbl[11] = mk(32'h12C, 32'h000090E7, OptNOP,   32'h0,        5'd0, 5'd0, 0, 0, 0, 1);
      tbl[12] = mk(32'h130, 32'h021080B3, OptNOP,   32'h0,        5'd0, 5'd0, 0, 0, 0, 1);
      tbl[13] = mk(32'h134, 32'h00001397, OptAUIPC, 32'h1000,     5'd7, 5'd0, 1, 0, 0, 0);

      rst = 1'b1; flush = 1'b0; inst_valid_i = 1'b0; ready_i = 1'b0;
      pc_i = '0; inst_i = '0; fwd_we_i = 1'b0; fwd_waddr_i = '0; fwd_wdata_i = '0;
      cur = tbl[0];

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready_low", inst_ready_o, 0);
      check("rst_fields",
            {valid_o, illegal_o, we_o, pc_o, rdata1_o, rdata2_o, imm_o, opcode_o, opt_o, waddr_o, shamt_o},
            {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, OpcodeNOP, OptNOP, 5'd0, 5'd0});
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", inst_ready_o, 1);
      check("empty_reads", {re1_o, re2_o, raddr1_o, raddr2_o}, 0);

      // Decode vectors, one at a time into an empty queue, EX always ready.
      ready_i = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1 offer(tbl[i]);
         @(posedge clk); #1 inst_valid_i = 1'b0;
         @(negedge clk);
         check($sformatf("head_reads_%0d", i), {valid_o, re1_o, re2_o, raddr1_o, raddr2_o},
               {1'b0, tbl[i].re1, tbl[i].re2, tbl[i].inst[19:15], tbl[i].inst[24:20]});
         @(negedge clk);
         check($sformatf("latency_%0d", i), valid_o, 1);
         @(negedge clk);
      end

      // Backpressure: EX stalled, IF offers continuously.
      @(posedge clk); #1 ready_i = 1'b0;
      acc = 0; k = 0;
      offer(tbl[0]);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk); a = inst_ready_o;
         @(posedge clk); #1;
         if (a) begin acc++; k++; offer(tbl[k]); end
      end
      inst_valid_i = 1'b0;
      check("bp_accepted", acc, 5);
      @(negedge clk);
      check("bp_full_ready", inst_ready_o, 0);
      base = n_out;
      @(posedge clk); #1 ready_i = 1'b1;
      ok = 1'b1;
      for (int c = 0; c < 5; c++) begin @(negedge clk); ok &= valid_o; end
      check("drain_rate", ok, 1);
      vcnt = 0;
      for (int c = 0; c < 3; c++) begin @(negedge clk); vcnt += int'(valid_o); end
      check("drain_done", vcnt, 0);
      check("drain_count", n_out - base, 5);

      // Flush with three queued entries and a simultaneous offer.
      @(posedge clk); #1 ready_i = 1'b0;
      for (int i = 5; i < 9; i++) begin offer(tbl[i]); @(posedge clk); #1; end
      offer(tbl[9]); flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0; inst_valid_i = 1'b0;
      @(negedge clk);
      check("flush_valid", valid_o, 0);
      check("flush_ready", inst_ready_o, 1);
      check("flush_keep_pc", pc_o, tbl[5].pc);
      check("flush_empty", {re1_o, re2_o, raddr1_o, raddr2_o}, 0);
      base = n_out;
      @(posedge clk); #1 ready_i = 1'b1; offer(tbl[10]);
      @(posedge clk); #1 inst_valid_i = 1'b0;
      repeat (5) @(negedge clk);
      check("flush_out_count", n_out - base, 1);

      // Pointer wrap: 10 items with EX ready toggling every cycle.
      base = n_out; k = 0;
      @(posedge clk); #1 offer(tbl[0]);
      for (int c = 0; c < 60 && k < 10; c++) begin
         @(negedge clk); a = inst_valid_i && inst_ready_o;
         @(posedge clk); #1 ready_i = ~ready_i;
         if (a) begin
            k++;
            if (k < 10) offer(tbl[k]); else inst_valid_i = 1'b0;
         end
      end
      check("wrap_accepted", k, 10);
      ready_i = 1'b1;
      repeat (10) @(negedge clk);
      check("wrap_out_count", n_out - base, 10);
      check("wrap_sb_empty", sb.size(), 0);

`ifdef ID_FWD_EN
      // Forwarding: both sources match x1 at the load edge, then a write to x0 is ignored.
      base = n_out;
      @(posedge clk); #1 offer(mk(32'h300, 32'h00108133, OptADD, 32'h0, 5'd2, 5'd0, 1, 1, 1, 0));
      cur.rd1 = 32'h1234; cur.rd2 = 32'h1234;
      @(posedge clk); #1 inst_valid_i = 1'b0; fwd_we_i = 1'b1; fwd_waddr_i = 5'd1; fwd_wdata_i = 32'h1234;
      @(posedge clk); #1 fwd_we_i = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 offer(mk(32'h304, 32'h00108133, OptADD, 32'h0, 5'd2, 5'd0, 1, 1, 1, 0));
      @(posedge clk); #1 inst_valid_i = 1'b0; fwd_we_i = 1'b1; fwd_waddr_i = 5'd0; fwd_wdata_i = 32'h1234;
      @(posedge clk); #1 fwd_we_i = 1'b0;
      repeat (2) @(negedge clk);
      check("fwd_out_count", n_out - base, 2);
`endif

      // Reset mid-operation discards everything, including an offer on the reset edge.
      @(posedge clk); #1 ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin offer(tbl[i]); @(posedge clk); #1; end
      offer(tbl[3]); rst = 1'b1;
      @(negedge clk);
      check("midrst_ready_low", inst_ready_o, 0);
      @(posedge clk); #1 rst = 1'b0; inst_valid_i = 1'b0; ready_i = 1'b1;
      @(negedge clk);
      check("midrst_state", {valid_o, inst_ready_o, re1_o, re2_o, raddr1_o, raddr2_o, pc_o},
            {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0});
      vcnt = 0;
      for (int c = 0; c < 4; c++) begin @(negedge clk); vcnt += int'(valid_o); end
      check("midrst_no_out", vcnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
